// File: rtl/bus_fabric.sv
// Single-master to NSLAVES data-bus fabric with base/mask decode, one outstanding
// transaction, unmapped-address error, per-transaction timeout and saturating error count.
module bus_fabric #(
   parameter int unsigned                    NSLAVES    = 4,
   parameter int unsigned                    ADDR_WIDTH = 32,
   parameter int unsigned                    DATA_WIDTH = 32,
   parameter logic [NSLAVES*ADDR_WIDTH-1:0]  SLAVE_BASE = '0,
   parameter logic [NSLAVES*ADDR_WIDTH-1:0]  SLAVE_MASK = '0,
   parameter int unsigned                    TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0]          ERR_RDATA  = DATA_WIDTH'(32'hDEADBEEF)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            m_req,
   input  logic                            m_we,
   input  logic [ADDR_WIDTH-1:0]           m_addr,
   input  logic [DATA_WIDTH-1:0]           m_wdata,
   input  logic [DATA_WIDTH/8-1:0]         m_wstrb,
   output logic                            m_ready,
   output logic                            m_rvalid,
   output logic [DATA_WIDTH-1:0]           m_rdata,
   output logic                            m_err,
   output logic [NSLAVES-1:0]              s_req,
   output logic                            s_we,
   output logic [ADDR_WIDTH-1:0]           s_addr,
   output logic [DATA_WIDTH-1:0]           s_wdata,
   output logic [DATA_WIDTH/8-1:0]         s_wstrb,
   input  logic [NSLAVES-1:0]              s_ready,
   input  logic [NSLAVES-1:0]              s_rvalid,
   input  logic [NSLAVES*DATA_WIDTH-1:0]   s_rdata,
   output logic [15:0]                     err_count
);

   localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

   state_t                  state_q;
   logic [SW-1:0]           sel_q;
   logic [TW-1:0]           tmo_q;
   logic                    s_we_q;
   logic [ADDR_WIDTH-1:0]   s_addr_q;
   logic [DATA_WIDTH-1:0]   s_wdata_q;
   logic [DATA_WIDTH/8-1:0] s_wstrb_q;
   logic                    m_rvalid_q;
   logic                    m_err_q;
   logic [DATA_WIDTH-1:0]   m_rdata_q;
   logic [15:0]             err_count_q;
   logic [15:0]             err_count_d;

   logic                    hit;
   logic [SW-1:0]           hit_idx;
   logic                    sel_ready;
   logic                    sel_rvalid;
   logic [DATA_WIDTH-1:0]   sel_rdata;

   // Ascending scan with a found flag: the lowest-index match wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < NSLAVES; i++) begin
         if (!hit && ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                      SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   always_comb begin
      sel_ready  = 1'b0;
      sel_rvalid = 1'b0;
      sel_rdata  = '0;
      s_req      = '0;
      for (int unsigned i = 0; i < NSLAVES; i++) begin
         if (SW'(i) == sel_q) begin
            sel_ready  = s_ready[i];
            sel_rvalid = s_rvalid[i];
            sel_rdata  = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            s_req[i]   = (state_q == ST_REQ);
         end
      end
   end

   assign err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= '0;
         tmo_q       <= '0;
         s_we_q      <= 1'b0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
         s_wstrb_q   <= '0;
         m_rvalid_q  <= 1'b0;
         m_err_q     <= 1'b0;
         m_rdata_q   <= '0;
         err_count_q <= '0;
      end else begin
         m_rvalid_q <= 1'b0;
         m_err_q    <= 1'b0;
         m_rdata_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (m_req) begin
                  s_we_q    <= m_we;
                  s_addr_q  <= m_addr;
                  s_wdata_q <= m_wdata;
                  s_wstrb_q <= m_wstrb;
                  if (hit) begin
                     sel_q   <= hit_idx;
                     tmo_q   <= '0;
                     state_q <= ST_REQ;
                  end else begin
                     state_q     <= ST_RESP;
                     m_rvalid_q  <= 1'b1;
                     m_err_q     <= 1'b1;
                     m_rdata_q   <= m_we ? '0 : ERR_RDATA;
                     err_count_q <= err_count_d;
                  end
               end
            end
            ST_REQ, ST_WAIT: begin
               // Completion is checked before the timeout so a last-cycle response wins.
               if (!s_we_q && sel_rvalid && (state_q == ST_WAIT || sel_ready)) begin
                  state_q    <= ST_RESP;
                  m_rvalid_q <= 1'b1;
                  m_rdata_q  <= sel_rdata;
               end else if (state_q == ST_REQ && s_we_q && sel_ready) begin
                  state_q    <= ST_RESP;
                  m_rvalid_q <= 1'b1;
               end else if (tmo_q == TMO_LAST) begin
                  state_q     <= ST_RESP;
                  m_rvalid_q  <= 1'b1;
                  m_err_q     <= 1'b1;
                  m_rdata_q   <= s_we_q ? '0 : ERR_RDATA;
                  err_count_q <= err_count_d;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
                  if (state_q == ST_REQ && sel_ready) begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m_ready   = (state_q == ST_IDLE);
   assign m_rvalid  = m_rvalid_q;
   assign m_rdata   = m_rdata_q;
   assign m_err     = m_err_q;
   assign s_we      = s_we_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign s_wstrb   = s_wstrb_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: directed transactions push expected responses,
// a negedge monitor pops and compares each m_rvalid pulse including its cycle.
module tb_bus_fabric;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_ready, m_rvalid, m_err;
   logic [31:0] m_rdata;
   logic [2:0]  s_req;
   logic        s_we;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [2:0]  s_ready, s_rvalid;
   logic [95:0] s_rdata;
   logic [15:0] err_count;

   logic        b_m_ready, b_m_rvalid, b_m_err;
   logic [31:0] b_m_rdata;
   logic [2:0]  b_s_req;
   logic        b_s_we;
   logic [31:0] b_s_addr, b_s_wdata;
   logic [3:0]  b_s_wstrb;
   logic [15:0] b_err_count;

   always #5 clk = ~clk;

   bus_fabric #(
      .NSLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .SLAVE_BASE({32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
      .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
      .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rvalid(m_rvalid),
      .m_rdata(m_rdata), .m_err(m_err), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rvalid(s_rvalid),
      .s_rdata(s_rdata), .err_count(err_count)
   );

   // Second fabric where slave0 (mask 0) overlaps every other slave.
   bus_fabric #(
      .NSLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .SLAVE_BASE({32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
      .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0000}),
      .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF)
   ) dut_ovl (
      .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(b_m_ready), .m_rvalid(b_m_rvalid),
      .m_rdata(b_m_rdata), .m_err(b_m_err), .s_req(b_s_req), .s_we(b_s_we),
      .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_ready(s_ready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .err_count(b_err_count)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] rdata, input logic err, input int at);
      exp_t e;
      e.rdata = rdata;
      e.err   = err;
      e.cyc   = at;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && m_rvalid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual=rvalid expected=none rdata=%h err=%b (cycle %0d)",
                     m_rdata, m_err, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_rdata", m_rdata, e.rdata);
            chk("rsp_err", {31'b0, m_err}, {31'b0, e.err});
            chk("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int c0;
      rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      s_ready = '0; s_rvalid = '0; s_rdata = '0;
      tick(); tick();
      @(negedge clk);
      chk("rst_m_ready", {31'b0, m_ready}, 32'd1);
      chk("rst_m_rvalid", {31'b0, m_rvalid}, 32'd0);
      chk("rst_s_req", {29'b0, s_req}, 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_err_count", {16'b0, err_count}, 32'd0);

      // Mapped read, slave1, zero-wait slave.
      tick(); rst = 1'b0;
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0001_0004;
      push(32'h1234_5678, 1'b0, c0 + 3);
      @(negedge clk);
      chk("rd_s_req_c0", {29'b0, s_req}, 32'd0);
      tick(); m_req = 1'b0; s_ready = 3'b010;
      @(negedge clk);
      chk("rd_s_req_c1", {29'b0, s_req}, 32'b010);
      chk("rd_s_addr", s_addr, 32'h0001_0004);
      chk("rd_m_ready_c1", {31'b0, m_ready}, 32'd0);
      tick(); s_ready = '0; s_rvalid = 3'b010;
      s_rdata = {32'hAAAA_0002, 32'h1234_5678, 32'hAAAA_0000};
      @(negedge clk);
      chk("rd_s_req_c2", {29'b0, s_req}, 32'd0);
      tick(); s_rvalid = '0; s_rdata = '0;
      tick();

      // Mapped write, slave0 ready after two wait cycles.
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0010; m_wdata = 32'hCAFE_F00D; m_wstrb = 4'b0011;
      push(32'h0, 1'b0, c0 + 4);
      tick(); m_req = 1'b0; m_wdata = 32'h1111_1111; m_wstrb = 4'b1111; m_addr = 32'h8000_0000;
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) s_ready = 3'b001;
         @(negedge clk);
         chk("wr_s_req", {29'b0, s_req}, 32'b001);
         chk("wr_s_wdata", s_wdata, 32'hCAFE_F00D);
         chk("wr_s_wstrb", {28'b0, s_wstrb}, 32'b0011);
         chk("wr_s_we", {31'b0, s_we}, 32'd1);
         tick();
      end
      s_ready = '0;
      tick();

      // Unmapped read, then unmapped write.
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0000;
      push(32'hDEAD_BEEF, 1'b1, c0 + 1);
      tick(); m_req = 1'b0;
      @(negedge clk);
      chk("unm_s_req", {29'b0, s_req}, 32'd0);
      chk("unm_err_count", {16'b0, err_count}, 32'd1);
      tick();
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b1; m_addr = 32'h9000_0000; m_wdata = 32'hFFFF_FFFF;
      push(32'h0, 1'b1, c0 + 1);
      tick(); m_req = 1'b0;
      @(negedge clk);
      chk("unm_wr_err_count", {16'b0, err_count}, 32'd2);
      tick();

      // Read to slave2 that never returns data: timeout after 8 cycles in REQ/WAIT.
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0002_0000;
      push(32'hDEAD_BEEF, 1'b1, c0 + 9);
      for (int k = 1; k <= 11; k++) begin
         tick();
         m_req    = 1'b0;
         s_ready  = (k == 1) ? 3'b100 : (k == 3 || k == 4) ? 3'b011 : (k == 10) ? 3'b100 : 3'b000;
         s_rvalid = (k == 3 || k == 4) ? 3'b011 : (k == 10) ? 3'b100 : 3'b000;
         s_rdata  = {32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
         @(negedge clk);
         if (k == 1) chk("tmo_s_req_c1", {29'b0, s_req}, 32'b100);
         if (k == 2) chk("tmo_s_req_c2", {29'b0, s_req}, 32'd0);
         if (k == 9) chk("tmo_err_count", {16'b0, err_count}, 32'd3);
      end
      s_rdata = '0;
      tick();

      // Completion on the last allowed cycle wins over the timeout.
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0002_0004;
      push(32'h7777_8888, 1'b0, c0 + 9);
      for (int k = 1; k <= 9; k++) begin
         tick();
         m_req    = 1'b0;
         s_ready  = (k == 1) ? 3'b100 : 3'b000;
         s_rvalid = (k == 8) ? 3'b100 : 3'b000;
         s_rdata  = (k == 8) ? {32'h7777_8888, 64'h0} : '0;
      end
      @(negedge clk);
      chk("edge_err_count", {16'b0, err_count}, 32'd3);
      tick();

      // Reset while waiting for read data abandons the transaction.
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0001_0000;
      tick(); m_req = 1'b0; s_ready = 3'b010;
      tick(); s_ready = '0; rst = 1'b1;
      @(negedge clk);
      chk("rstw_s_req", {29'b0, s_req}, 32'd0);
      tick(); rst = 1'b0;

      // Next request after reset: overlap decode plus same-cycle ready/rvalid.
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0001_0040;
      push(32'h0BAD_F00D, 1'b0, c0 + 2);
      @(negedge clk);
      chk("rstw_m_ready", {31'b0, m_ready}, 32'd1);
      chk("rstw_m_rvalid", {31'b0, m_rvalid}, 32'd0);
      chk("rstw_err_count", {16'b0, err_count}, 32'd0);
      tick(); m_req = 1'b0; s_ready = 3'b011; s_rvalid = 3'b011;
      s_rdata = {32'hAAAA_0002, 32'h0BAD_F00D, 32'h5A5A_0000};
      @(negedge clk);
      chk("ovl_a_s_req", {29'b0, s_req}, 32'b010);
      chk("ovl_b_s_req", {29'b0, b_s_req}, 32'b001);
      tick(); s_ready = '0; s_rvalid = '0; s_rdata = '0;
      @(negedge clk);
      chk("ovl_b_rvalid", {31'b0, b_m_rvalid}, 32'd1);
      chk("ovl_b_rdata", b_m_rdata, 32'h5A5A_0000);
      chk("ovl_b_err", {31'b0, b_m_err}, 32'd0);

      // Back-to-back: accepted in the IDLE cycle right after RESP.
      tick();
      c0 = cyc;
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'hF000_0000;
      push(32'hDEAD_BEEF, 1'b1, c0 + 1);
      @(negedge clk);
      chk("b2b_m_ready", {31'b0, m_ready}, 32'd1);
      tick(); m_req = 1'b0;
      @(negedge clk);
      chk("b2b_err_count", {16'b0, err_count}, 32'd1);
      tick(); tick(); tick();

      chk("sb_drain", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
